// File: rtl/spi_host_pkg.sv
// Shared constants for the spi_host MMIO SPI master: register map, FSM encoding
// and control/status bit positions.
package spi_host_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_DIVISOR = 8'h0a;
  localparam logic [7:0] ADDR_SS      = 8'h0b;
  localparam logic [7:0] ADDR_CONFIG  = 8'h0c;
  localparam logic [7:0] ADDR_TX_DATA = 8'h10;
  localparam logic [7:0] ADDR_RX_DATA = 8'h11;

  localparam int CTRL_START  = 0;
  localparam int STATUS_BUSY = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCK_LO = 2'd1,
    ST_SCK_HI = 2'd2
  } state_t;

endpackage

// File: rtl/spi_host_shifter.sv
// Byte shifter for spi_host: tx/rx shift registers, bit counter and bit order.
// Driven by load/sample/shift/latch strobes from the sequencing FSM.
module spi_host_shifter
  import spi_host_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_sample,
  input  logic       i_shift,
  input  logic       i_latch,
  input  logic       i_lsb_first,
  input  logic [7:0] i_tx_data,
  input  logic       i_miso,
  output logic       o_mosi,
  output logic       o_last,
  output logic [7:0] o_rx_data
);

  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic [2:0] r_bit_ctr;
  logic       r_mosi;
  logic [7:0] r_rx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_ctr  <= '0;
      r_mosi     <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      if (i_load) begin
        r_tx_shift <= i_tx_data;
        r_bit_ctr  <= '0;
        r_mosi     <= i_lsb_first ? i_tx_data[0] : i_tx_data[7];
      end else if (i_shift) begin
        r_bit_ctr <= r_bit_ctr + 3'd1;
        if (i_lsb_first) begin
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          r_mosi     <= r_tx_shift[1];
        end else begin
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          r_mosi     <= r_tx_shift[6];
        end
      end
      // LSB-first assembles from the top so the first bit ends in bit0
      if (i_sample)
        r_rx_shift <= i_lsb_first ? {i_miso, r_rx_shift[7:1]} : {r_rx_shift[6:0], i_miso};
      if (i_latch)
        r_rx_data <= r_rx_shift;
    end
  end

  assign o_mosi    = r_mosi;
  assign o_last    = (r_bit_ctr == 3'd7);
  assign o_rx_data = r_rx_data;

endmodule

// File: rtl/spi_host.sv
// MMIO SPI master, mode 0, 8-bit transfers, software chip select, programmable SCK divider.
// Optional LSB-first CONFIG register enabled by defining SPI_HOST_LSB_FIRST_EN.
module spi_host
  import spi_host_pkg::*;
#(
  parameter int                   DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        spi_ss,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  state_t r_state;
  state_t w_next;

  logic [DIV_WIDTH-1:0] r_divisor;
  logic [DIV_WIDTH-1:0] r_div_ctr;
  logic [DIV_WIDTH-1:0] w_div_max;
  logic [7:0]           r_tx_data;
  logic                 r_ss;
  logic                 r_sck;
  logic                 r_ready;
  logic [31:0]          r_rdata;
  logic [31:0]          w_rdata;

  logic w_busy, w_wr, w_start, w_tc, w_last;
  logic w_load, w_sample, w_shift, w_latch;
  logic w_lsb_first;
  logic [7:0] w_rx_data;
  logic w_unused;

  assign w_unused = ^write_data;
  assign w_busy   = (r_state != ST_IDLE);
  assign w_wr     = cs & we;
  assign w_start  = w_wr && (address == ADDR_CTRL) && write_data[CTRL_START] && !w_busy;

  // A divisor of 0 behaves as 1
  assign w_div_max = (r_divisor == '0) ? '0 : r_divisor - DIV_WIDTH'(1);
  assign w_tc      = (r_div_ctr == w_div_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_sample = 1'b0;
    w_shift  = 1'b0;
    w_latch  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_load = 1'b1;
          w_next = ST_SCK_LO;
        end
      end
      ST_SCK_LO: begin
        if (w_tc) begin
          w_sample = 1'b1;
          w_next   = ST_SCK_HI;
        end
      end
      ST_SCK_HI: begin
        if (w_tc) begin
          if (w_last) begin
            w_latch = 1'b1;
            w_next  = ST_IDLE;
          end else begin
            w_shift = 1'b1;
            w_next  = ST_SCK_LO;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_ctr <= '0;
      r_sck     <= 1'b0;
    end else begin
      if (w_load || (w_busy && w_tc))
        r_div_ctr <= '0;
      else if (w_busy)
        r_div_ctr <= r_div_ctr + DIV_WIDTH'(1);
      if (w_sample)
        r_sck <= 1'b1;
      else if (r_state == ST_SCK_HI && w_tc)
        r_sck <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_divisor <= DIV_RESET;
      r_tx_data <= '0;
      r_ss      <= 1'b1;
    end else if (w_wr) begin
      if (address == ADDR_DIVISOR && !w_busy) r_divisor <= write_data[DIV_WIDTH-1:0];
      if (address == ADDR_TX_DATA && !w_busy) r_tx_data <= write_data[7:0];
      if (address == ADDR_SS)                 r_ss      <= write_data[0];
    end
  end

`ifdef SPI_HOST_LSB_FIRST_EN
  logic r_lsb_first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_lsb_first <= 1'b0;
    else if (w_wr && address == ADDR_CONFIG && !w_busy)
      r_lsb_first <= write_data[0];
  end

  assign w_lsb_first = r_lsb_first;
`else
  assign w_lsb_first = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_STATUS:  w_rdata[STATUS_BUSY]    = w_busy;
      ADDR_DIVISOR: w_rdata[DIV_WIDTH-1:0]  = r_divisor;
      ADDR_SS:      w_rdata[0]              = r_ss;
      ADDR_TX_DATA: w_rdata[7:0]            = r_tx_data;
      ADDR_RX_DATA: w_rdata[7:0]            = w_rx_data;
`ifdef SPI_HOST_LSB_FIRST_EN
      ADDR_CONFIG:  w_rdata[0]              = w_lsb_first;
`endif
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= cs;
      r_rdata <= cs ? w_rdata : '0;
    end
  end

  spi_host_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_sample   (w_sample),
    .i_shift    (w_shift),
    .i_latch    (w_latch),
    .i_lsb_first(w_lsb_first),
    .i_tx_data  (r_tx_data),
    .i_miso     (spi_miso),
    .o_mosi     (spi_mosi),
    .o_last     (w_last),
    .o_rx_data  (w_rx_data)
  );

  assign read_data = r_rdata;
  assign ready     = r_ready;
  assign spi_ss    = r_ss;
  assign spi_sck   = r_sck;

endmodule

// File: tb/tb_spi_host.sv
// Directed self-checking bench for spi_host: register access, transfer timing,
// divider edge cases, busy protection, chip select and mid-transfer reset.
module tb_spi_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  wire  [31:0] read_data;
  wire         ready;
  wire         spi_ss;
  wire         spi_sck;
  wire         spi_mosi;
  wire         spi_miso;

  logic       r_loop;
  logic       r_miso;
  logic [7:0] r_pat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  int dur, rises, hi;
  logic [31:0] rd;

  assign spi_miso = r_loop ? spi_mosi : r_miso;

  spi_host dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .we        (we),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .spi_ss    (spi_ss),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; write_data = '0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    @(negedge clk);
    d  = read_data;
    cs = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic start_xfer();
    bus_wr(8'h08, 32'h1);
    t0 = cyc;
  endtask

  // Polls STATUS every cycle; dur is start edge to first idle edge in clk cycles.
  task automatic wait_idle(output int o_dur, output int o_rises, output int o_hi);
    logic prev;
    prev = 1'b0; o_rises = 0; o_hi = 0; o_dur = -1;
    cs = 1'b1; we = 1'b0; address = 8'h09;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (spi_sck) begin
        o_hi++;
        if (!prev) begin
          o_rises++;
          if (o_rises < 8) r_miso = r_pat[7 - o_rises];
        end
      end
      prev = spi_sck;
      if (ready && read_data[0] == 1'b0) begin
        o_dur = cyc - t0 - 1;
        break;
      end
    end
    cs = 1'b0;
    if (o_dur < 0) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
    r_loop = 1'b0; r_miso = 1'b0; r_pat = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ss", spi_ss, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ready", ready, 0);
    check("rst_rdata", read_data, 0);
    reset = 1'b0;

    rd_chk("rst_status", 8'h09, 32'h0);
    rd_chk("rst_div", 8'h0a, 32'h4);
    bus_rd(8'h0b, rd);
    check("rst_ss_reg", rd, 32'h1);
    check("ready_pulse", ready, 1);
    @(negedge clk);
    check("ready_drop", ready, 0);
    check("rdata_idle", read_data, 0);
    rd_chk("rst_rx", 8'h11, 32'h0);
    rd_chk("rst_tx", 8'h10, 32'h0);

    rd_chk("unmapped_rd", 8'h20, 32'h0);
    bus_wr(8'h20, 32'hffff_ffff);
    rd_chk("unmapped_wr", 8'h0a, 32'h4);
    bus_wr(8'h0c, 32'h1);
`ifdef SPI_HOST_LSB_FIRST_EN
    rd_chk("config_rd", 8'h0c, 32'h1);
    bus_wr(8'h0c, 32'h0);
`else
    rd_chk("config_rd", 8'h0c, 32'h0);
`endif

    // Loopback, divisor 2
    r_loop = 1'b1;
    bus_wr(8'h0a, 32'h2);
    bus_wr(8'h10, 32'ha5);
    start_xfer();
    check("lb_first_mosi", spi_mosi, 1);
    wait_idle(dur, rises, hi);
    check("lb_dur", dur, 32);
    check("lb_rises", rises, 8);
    check("lb_hi", hi, 16);
    rd_chk("lb_rx", 8'h11, 32'ha5);

    // Divisor 0 behaves as 1
    bus_wr(8'h0a, 32'h0);
    rd_chk("div0_rd", 8'h0a, 32'h0);
    bus_wr(8'h10, 32'h5a);
    start_xfer();
    wait_idle(dur, rises, hi);
    check("div0_dur", dur, 16);
    check("div0_rises", rises, 8);
    check("div0_hi", hi, 8);
    rd_chk("div0_rx", 8'h11, 32'h5a);

    bus_wr(8'h0a, 32'h1);
    bus_wr(8'h10, 32'h3c);
    start_xfer();
    wait_idle(dur, rises, hi);
    check("div1_dur", dur, 16);
    rd_chk("div1_rx", 8'h11, 32'h3c);

    // Independent miso pattern, divisor 3
    r_loop = 1'b0; r_pat = 8'h96; r_miso = 1'b1;
    bus_wr(8'h0a, 32'h3);
    bus_wr(8'h10, 32'h00);
    start_xfer();
    check("pat_first_mosi", spi_mosi, 0);
    wait_idle(dur, rises, hi);
    check("pat_dur", dur, 48);
    check("pat_hi", hi, 24);
    rd_chk("pat_rx", 8'h11, 32'h96);

    // Writes while busy are ignored
    r_loop = 1'b1;
    bus_wr(8'h0a, 32'h2);
    bus_wr(8'h10, 32'ha5);
    start_xfer();
    bus_wr(8'h10, 32'h3c);
    bus_wr(8'h0a, 32'h7);
    bus_wr(8'h08, 32'h1);
    rd_chk("busy_rx_prev", 8'h11, 32'h96);
    wait_idle(dur, rises, hi);
    check("busy_dur", dur, 32);
    rd_chk("busy_rx", 8'h11, 32'ha5);
    rd_chk("busy_tx", 8'h10, 32'ha5);
    rd_chk("busy_div", 8'h0a, 32'h2);

    // SS follows writes mid-transfer
    start_xfer();
    bus_wr(8'h0b, 32'h0);
    check("ss_low", spi_ss, 0);
    bus_wr(8'h0b, 32'h1);
    check("ss_high", spi_ss, 1);
    bus_wr(8'h0b, 32'h0);
    check("ss_low2", spi_ss, 0);
    wait_idle(dur, rises, hi);
    check("ss_dur", dur, 32);
    rd_chk("ss_reg", 8'h0b, 32'h0);
    bus_wr(8'h0b, 32'h1);

    // Reset after three bits
    bus_wr(8'h10, 32'hff);
    start_xfer();
    repeat (13) @(negedge clk);
    check("pre_rst_mosi", spi_mosi, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_sck", spi_sck, 0);
    check("mid_rst_mosi", spi_mosi, 0);
    check("mid_rst_ss", spi_ss, 1);
    check("mid_rst_ready", ready, 0);
    reset = 1'b0;
    rd_chk("mid_rst_status", 8'h09, 32'h0);
    rd_chk("mid_rst_rx", 8'h11, 32'h0);
    rd_chk("mid_rst_div", 8'h0a, 32'h4);
    rd_chk("mid_rst_tx", 8'h10, 32'h0);

    // Maximum divisor: first half-period is still in progress well after start
    bus_wr(8'h0a, 32'hffff);
    rd_chk("max_div_rd", 8'h0a, 32'hffff);
    start_xfer();
    repeat (2000) @(negedge clk);
    check("max_sck_low", spi_sck, 0);
    rd_chk("max_busy", 8'h09, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_chk("max_abort", 8'h09, 32'h0);

`ifdef SPI_HOST_LSB_FIRST_EN
    r_loop = 1'b0; r_pat = 8'h80; r_miso = 1'b1;
    bus_wr(8'h0c, 32'h1);
    bus_wr(8'h0a, 32'h2);
    bus_wr(8'h10, 32'h01);
    start_xfer();
    check("lsb_first_mosi", spi_mosi, 1);
    wait_idle(dur, rises, hi);
    check("lsb_dur", dur, 32);
    rd_chk("lsb_rx", 8'h11, 32'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
